// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares one DMI debug-module port between two requesters,
// with at most one transaction outstanding at a time.
// Optional feature macro: DMI_ARB_TIMEOUT_EN. When it is defined, a response
// that has not arrived after TIMEOUT_CYCLES cycles is answered with a
// synthetic error, and the late real response is drained and dropped.
module dmi_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  // requester 0
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [6:0]  m0_req_bits_addr,
  input  logic [1:0]  m0_req_bits_op,
  input  logic [31:0] m0_req_bits_data,
  output logic        m0_resp_valid,
  input  logic        m0_resp_ready,
  output logic [1:0]  m0_resp_bits_resp,
  output logic [31:0] m0_resp_bits_data,
  // requester 1
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [6:0]  m1_req_bits_addr,
  input  logic [1:0]  m1_req_bits_op,
  input  logic [31:0] m1_req_bits_data,
  output logic        m1_resp_valid,
  input  logic        m1_resp_ready,
  output logic [1:0]  m1_resp_bits_resp,
  output logic [31:0] m1_resp_bits_data,
  // shared debug module
  output logic        dmi_req_valid,
  input  logic        dmi_req_ready,
  output logic [6:0]  dmi_req_bits_addr,
  output logic [1:0]  dmi_req_bits_op,
  output logic [31:0] dmi_req_bits_data,
  input  logic        dmi_resp_valid,
  output logic        dmi_resp_ready,
  input  logic [1:0]  dmi_resp_bits_resp,
  input  logic [31:0] dmi_resp_bits_data,
  output logic        owner
);

  // Reject out-of-range timeout settings at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dmi_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2
`ifdef DMI_ARB_TIMEOUT_EN
    , S_DRAIN = 2'd3
`endif
  } state_t;

  state_t      r_state;
  logic        r_rr;
  logic        r_owner;
  logic [6:0]  r_addr;
  logic [1:0]  r_op;
  logic [31:0] r_data;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;
  logic        r_stale;
`endif

  logic        w_grant;
  logic        w_req_hs;
  logic        w_own_ready;
  logic        w_fwd_valid;
  logic [1:0]  w_fwd_resp;
  logic [31:0] w_fwd_data;

  // Grant selection: a lone valid wins, a tie goes to the round-robin pointer.
  assign w_grant     = (m0_req_valid && m1_req_valid) ? r_rr : m1_req_valid;
  assign w_req_hs    = (r_state == S_IDLE) && (m0_req_valid || m1_req_valid);
  assign w_own_ready = r_owner ? m1_resp_ready : m0_resp_ready;

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    m0_req_ready      = 1'b0;
    m1_req_ready      = 1'b0;
    dmi_req_valid     = 1'b0;
    dmi_resp_ready    = 1'b0;
    w_fwd_valid       = 1'b0;
    w_fwd_resp        = 2'b00;
    w_fwd_data        = 32'h0;
    dmi_req_bits_addr = 7'h0;
    dmi_req_bits_op   = 2'b00;
    dmi_req_bits_data = 32'h0;
    owner             = 1'b0;
    if (!reset) begin
      dmi_req_bits_addr = r_addr;
      dmi_req_bits_op   = r_op;
      dmi_req_bits_data = r_data;
      owner             = r_owner;
      case (r_state)
        S_IDLE: begin
          m0_req_ready = m0_req_valid && !w_grant;
          m1_req_ready = m1_req_valid && w_grant;
        end
        S_REQ: begin
          dmi_req_valid = 1'b1;
        end
        S_RESP: begin
`ifdef DMI_ARB_TIMEOUT_EN
          if (r_stale) begin
            // Synthetic error response; the real one is dropped in DRAIN.
            w_fwd_valid = 1'b1;
            w_fwd_resp  = 2'b10;
            w_fwd_data  = 32'h0;
          end else
`endif
          begin
            w_fwd_valid    = dmi_resp_valid;
            dmi_resp_ready = w_own_ready;
            if (dmi_resp_valid) begin
              w_fwd_resp = dmi_resp_bits_resp;
              w_fwd_data = dmi_resp_bits_data;
            end
          end
        end
`ifdef DMI_ARB_TIMEOUT_EN
        S_DRAIN: begin
          dmi_resp_ready = 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
    m0_resp_valid     = w_fwd_valid && !r_owner;
    m0_resp_bits_resp = r_owner ? 2'b00 : w_fwd_resp;
    m0_resp_bits_data = r_owner ? 32'h0 : w_fwd_data;
    m1_resp_valid     = w_fwd_valid && r_owner;
    m1_resp_bits_resp = r_owner ? w_fwd_resp : 2'b00;
    m1_resp_bits_data = r_owner ? w_fwd_data : 32'h0;
  end

  // Transaction FSM: capture request, present it, wait for and route response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_addr  <= 7'h0;
      r_op    <= 2'b00;
      r_data  <= 32'h0;
`ifdef DMI_ARB_TIMEOUT_EN
      r_cnt   <= 16'h0;
      r_stale <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_owner <= w_grant;
            r_addr  <= w_grant ? m1_req_bits_addr : m0_req_bits_addr;
            r_op    <= w_grant ? m1_req_bits_op   : m0_req_bits_op;
            r_data  <= w_grant ? m1_req_bits_data : m0_req_bits_data;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmi_req_ready) begin
            r_state <= S_RESP;
`ifdef DMI_ARB_TIMEOUT_EN
            r_cnt   <= 16'h0;
            r_stale <= 1'b0;
`endif
          end
        end
        S_RESP: begin
`ifdef DMI_ARB_TIMEOUT_EN
          if (r_stale) begin
            if (w_own_ready) begin
              r_stale <= 1'b0;
              r_state <= S_DRAIN;
            end
          end else if (dmi_resp_valid) begin
            // A real response wins even in the cycle the timer would expire.
            if (w_own_ready) begin
              r_rr    <= ~r_owner;
              r_state <= S_IDLE;
            end
          end else if (r_cnt == LP_LAST) begin
            r_stale <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`else
          if (dmi_resp_valid && w_own_ready) begin
            r_rr    <= ~r_owner;
            r_state <= S_IDLE;
          end
`endif
        end
`ifdef DMI_ARB_TIMEOUT_EN
        S_DRAIN: begin
          if (dmi_resp_valid) begin
            r_rr    <= ~r_owner;
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed self-checking bench for dmi_arbiter.
module tb_dmi_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
  logic [6:0]  m0_req_bits_addr;
  logic [1:0]  m0_req_bits_op, m0_resp_bits_resp;
  logic [31:0] m0_req_bits_data, m0_resp_bits_data;
  logic        m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
  logic [6:0]  m1_req_bits_addr;
  logic [1:0]  m1_req_bits_op, m1_resp_bits_resp;
  logic [31:0] m1_req_bits_data, m1_resp_bits_data;
  logic        dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
  logic [6:0]  dmi_req_bits_addr;
  logic [1:0]  dmi_req_bits_op, dmi_resp_bits_resp;
  logic [31:0] dmi_req_bits_data, dmi_resp_bits_data;
  logic        owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
    .m0_req_bits_addr(m0_req_bits_addr), .m0_req_bits_op(m0_req_bits_op),
    .m0_req_bits_data(m0_req_bits_data),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_resp_bits_resp(m0_resp_bits_resp), .m0_resp_bits_data(m0_resp_bits_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
    .m1_req_bits_addr(m1_req_bits_addr), .m1_req_bits_op(m1_req_bits_op),
    .m1_req_bits_data(m1_req_bits_data),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_resp_bits_resp(m1_resp_bits_resp), .m1_resp_bits_data(m1_resp_bits_data),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_bits_addr(dmi_req_bits_addr), .dmi_req_bits_op(dmi_req_bits_op),
    .dmi_req_bits_data(dmi_req_bits_data),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_bits_resp(dmi_resp_bits_resp), .dmi_resp_bits_data(dmi_resp_bits_data),
    .owner(owner)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_req_valid = 0; m0_req_bits_addr = 0; m0_req_bits_op = 0; m0_req_bits_data = 0; m0_resp_ready = 0;
    m1_req_valid = 0; m1_req_bits_addr = 0; m1_req_bits_op = 0; m1_req_bits_data = 0; m1_resp_ready = 0;
    dmi_req_ready = 0; dmi_resp_valid = 0; dmi_resp_bits_resp = 0; dmi_resp_bits_data = 0;
    tick();
    tick();
    // Outputs held low during reset, even with a requester valid.
    m0_req_valid = 1;
    #1;
    chk("rst_m0_req_ready", 64'(m0_req_ready), 64'd0);
    chk("rst_dmi_req_valid", 64'(dmi_req_valid), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_dmi_req_addr", 64'(dmi_req_bits_addr), 64'd0);
    chk("rst_dmi_resp_ready", 64'(dmi_resp_ready), 64'd0);

    // Basic m0 transaction.
    reset = 0;
    m0_req_bits_addr = 7'h10; m0_req_bits_op = 2'd1; m0_req_bits_data = 32'h12345678;
    dmi_req_ready = 1;
    #1;
    chk("t1_m0_ready_idle", 64'(m0_req_ready), 64'd1);
    chk("t1_m1_ready_idle", 64'(m1_req_ready), 64'd0);
    chk("t1_dmi_valid_idle", 64'(dmi_req_valid), 64'd0);
    tick();
    m0_req_valid = 0;
    #1;
    chk("t1_dmi_valid_n1", 64'(dmi_req_valid), 64'd1);
    chk("t1_dmi_addr", 64'(dmi_req_bits_addr), 64'h10);
    chk("t1_dmi_op", 64'(dmi_req_bits_op), 64'd1);
    chk("t1_dmi_data", 64'(dmi_req_bits_data), 64'h12345678);
    chk("t1_owner", 64'(owner), 64'd0);
    tick();
    dmi_resp_valid = 1; dmi_resp_bits_resp = 0; dmi_resp_bits_data = 32'hDEADBEEF;
    m0_resp_ready = 1;
    #1;
    chk("t1_m0_resp_valid", 64'(m0_resp_valid), 64'd1);
    chk("t1_m0_resp_data", 64'(m0_resp_bits_data), 64'hDEADBEEF);
    chk("t1_m1_resp_valid", 64'(m1_resp_valid), 64'd0);
    chk("t1_m1_resp_data", 64'(m1_resp_bits_data), 64'd0);
    chk("t1_dmi_resp_ready", 64'(dmi_resp_ready), 64'd1);
    chk("t1_dmi_valid_resp", 64'(dmi_req_valid), 64'd0);
    tick();
    dmi_resp_valid = 0;
    #1;
    chk("t1_m0_resp_after", 64'(m0_resp_valid), 64'd0);
    $display("txn basic m0 done checks=%0d errors=%0d", checks, errors);

    // Round-robin from reset with both requesters always valid.
    reset = 1;
    tick();
    reset = 0;
    m0_req_valid = 1; m0_req_bits_addr = 7'h01;
    m1_req_valid = 1; m1_req_bits_addr = 7'h02;
    m0_resp_ready = 1; m1_resp_ready = 1;
    dmi_req_ready = 1; dmi_resp_valid = 1; dmi_resp_bits_data = 32'h0000_0042;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = 1'(i % 2);
      #1;
      chk("rr_m0_ready", 64'(m0_req_ready), 64'(!g));
      chk("rr_m1_ready", 64'(m1_req_ready), 64'(g));
      tick();
      chk("rr_owner", 64'(owner), 64'(g));
      chk("rr_dmi_addr", 64'(dmi_req_bits_addr), g ? 64'h02 : 64'h01);
      tick();
      chk("rr_m0_resp", 64'(m0_resp_valid), 64'(!g));
      chk("rr_m1_resp", 64'(m1_resp_valid), 64'(g));
      tick();
      $display("txn rr %0d owner=%0d", i, g);
    end

    // Request-side stall: payload must hold while dmi_req_ready is low.
    m1_req_valid = 0; dmi_resp_valid = 0; dmi_req_ready = 0;
    m0_req_valid = 1; m0_req_bits_addr = 7'h3A; m0_req_bits_op = 2'd2; m0_req_bits_data = 32'hA5A50F0F;
    #1;
    chk("st_m0_ready", 64'(m0_req_ready), 64'd1);
    tick();
    m0_req_bits_addr = 7'h7F; m0_req_bits_data = 32'h11111111;
    m1_req_valid = 1; m1_req_bits_addr = 7'h44; m1_req_bits_op = 2'd1; m1_req_bits_data = 32'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("st_dmi_valid", 64'(dmi_req_valid), 64'd1);
      chk("st_dmi_addr", 64'(dmi_req_bits_addr), 64'h3A);
      chk("st_dmi_data", 64'(dmi_req_bits_data), 64'hA5A50F0F);
      chk("st_m0_ready", 64'(m0_req_ready), 64'd0);
      chk("st_m1_ready", 64'(m1_req_ready), 64'd0);
      tick();
    end
    dmi_req_ready = 1;
    tick();
    dmi_resp_valid = 1; m0_resp_ready = 1;
    tick();
    $display("txn stall m0 done checks=%0d errors=%0d", checks, errors);

    // m1 owns; its response stalls for 3 cycles.
    dmi_resp_valid = 0;
    #1;
    chk("bp_m1_ready", 64'(m1_req_ready), 64'd1);
    chk("bp_m0_ready", 64'(m0_req_ready), 64'd0);
    tick();
    m0_req_valid = 0; m1_req_valid = 0;
    chk("bp_owner", 64'(owner), 64'd1);
    tick();
    dmi_resp_valid = 1; dmi_resp_bits_resp = 2'd1; dmi_resp_bits_data = 32'hCAFE0001;
    m1_resp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_dmi_resp_ready", 64'(dmi_resp_ready), 64'd0);
      chk("bp_m1_resp_valid", 64'(m1_resp_valid), 64'd1);
      chk("bp_m0_resp_valid", 64'(m0_resp_valid), 64'd0);
      chk("bp_m0_resp_data", 64'(m0_resp_bits_data), 64'd0);
      tick();
    end
    m1_resp_ready = 1;
    #1;
    chk("bp_dmi_resp_ready_go", 64'(dmi_resp_ready), 64'd1);
    chk("bp_m1_resp_resp", 64'(m1_resp_bits_resp), 64'd1);
    chk("bp_m1_resp_data", 64'(m1_resp_bits_data), 64'hCAFE0001);
    tick();
    dmi_resp_valid = 0;
    #1;
    chk("bp_m1_resp_after", 64'(m1_resp_valid), 64'd0);
    chk("bp_m1_data_after", 64'(m1_resp_bits_data), 64'd0);
    $display("txn backpressure m1 done checks=%0d errors=%0d", checks, errors);

    // Reset in RESP abandons the transaction.
    m0_req_valid = 1; m0_req_bits_addr = 7'h20;
    #1;
    chk("rs_m0_ready", 64'(m0_req_ready), 64'd1);
    tick();
    m0_req_valid = 0;
    tick();
    dmi_resp_valid = 1; dmi_resp_bits_data = 32'h5555AAAA; m0_resp_ready = 0;
    #1;
    chk("rs_m0_resp_pre", 64'(m0_resp_valid), 64'd1);
    reset = 1;
    #1;
    chk("rs_m0_resp_during", 64'(m0_resp_valid), 64'd0);
    chk("rs_dmi_resp_ready_during", 64'(dmi_resp_ready), 64'd0);
    tick();
    reset = 0; m0_resp_ready = 1;
    #1;
    chk("rs_m0_resp_after", 64'(m0_resp_valid), 64'd0);
    chk("rs_m0_data_after", 64'(m0_resp_bits_data), 64'd0);
    chk("rs_dmi_req_valid", 64'(dmi_req_valid), 64'd0);
    chk("rs_owner", 64'(owner), 64'd0);
    chk("rs_dmi_addr", 64'(dmi_req_bits_addr), 64'd0);
    dmi_resp_valid = 0;
    m1_req_valid = 1; m1_req_bits_addr = 7'h55; m1_req_bits_data = 32'h0;
    #1;
    chk("rs_m1_ready", 64'(m1_req_ready), 64'd1);
    tick();
    m1_req_valid = 0;
    chk("rs_m1_owner", 64'(owner), 64'd1);
    chk("rs_m1_addr", 64'(dmi_req_bits_addr), 64'h55);
    chk("rs_m1_dmi_valid", 64'(dmi_req_valid), 64'd1);
    tick();
    dmi_resp_valid = 1; dmi_resp_bits_resp = 0; dmi_resp_bits_data = 32'h0BADF00D; m1_resp_ready = 1;
    #1;
    chk("rs_m1_resp_valid", 64'(m1_resp_valid), 64'd1);
    chk("rs_m1_resp_data", 64'(m1_resp_bits_data), 64'h0BADF00D);
    tick();
    dmi_resp_valid = 0;
    $display("txn reset-abandon then m1 done checks=%0d errors=%0d", checks, errors);

`ifdef DMI_ARB_TIMEOUT_EN
    // Timeout: no response for 8 RESP cycles, late response drained.
    m0_req_valid = 1; m0_req_bits_addr = 7'h11; m0_resp_ready = 0;
    #1;
    chk("to_m0_ready", 64'(m0_req_ready), 64'd1);
    tick();
    m0_req_valid = 0;
    tick();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("to_wait_resp_valid", 64'(m0_resp_valid), 64'd0);
      tick();
    end
    #1;
    chk("to_syn_valid", 64'(m0_resp_valid), 64'd1);
    chk("to_syn_resp", 64'(m0_resp_bits_resp), 64'd2);
    chk("to_syn_data", 64'(m0_resp_bits_data), 64'd0);
    chk("to_syn_m1", 64'(m1_resp_valid), 64'd0);
    m0_resp_ready = 1;
    tick();
    m1_req_valid = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("to_drain_ready", 64'(dmi_resp_ready), 64'd1);
      chk("to_drain_grant", 64'(m1_req_ready), 64'd0);
      chk("to_drain_m0_resp", 64'(m0_resp_valid), 64'd0);
      tick();
    end
    dmi_resp_valid = 1; dmi_resp_bits_data = 32'h77777777;
    #1;
    chk("to_late_m0_resp", 64'(m0_resp_valid), 64'd0);
    chk("to_late_grant", 64'(m1_req_ready), 64'd0);
    tick();
    dmi_resp_valid = 0;
    #1;
    chk("to_after_grant", 64'(m1_req_ready), 64'd1);
    m1_req_valid = 0;
    $display("txn timeout m0 done checks=%0d errors=%0d", checks, errors);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
